// File: rtl/priority_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : priority_pkg
//  Description : Shared definitions for the priority encoder / index
//                serializer pair: default width, index-width and frame-length
//                helpers, and the serializer state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package priority_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Bit-index width for a one-hot of the given width. A 1-bit floor keeps
  // the index buses legal even for degenerate widths.
  function automatic int idx_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

  // Serial frame length: NZ flag followed by the left and right indices.
  function automatic int frame_len(input int width);
    return 1 + 2 * idx_w(width);
  endfunction

  localparam int FRAME_LEN = frame_len(DEFAULT_WIDTH);

  // The state names the field currently being presented on the serial line.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLAG  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } state_t;

endpackage : priority_pkg
`default_nettype wire

// File: rtl/priority_index_serializer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : priority_index_serializer_if
//  Description : Bundles the one-hot input pair and the serial output side of
//                the index serializer.
//  Ports       : data_left_i / data_right_i [WIDTH] - one-hot pair
//                data_val_i      - pair valid (single-cycle pulse)
//                ser_data_o      - serial frame bit
//                ser_data_val_o  - serial bit valid
//                busy_o          - frame in progress, inputs ignored
//                err_o           - malformed pair pulse
//                modport master: drives the pair; modport slave: the serializer
//  Revision    : 1.0 - initial release
// ============================================================================
interface priority_index_serializer_if
  import priority_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] data_left_i;
  logic [WIDTH-1:0] data_right_i;
  logic             data_val_i;
  logic             ser_data_o;
  logic             ser_data_val_o;
  logic             busy_o;
  logic             err_o;

  modport master (
    output data_left_i,
    output data_right_i,
    output data_val_i,
    input  ser_data_o,
    input  ser_data_val_o,
    input  busy_o,
    input  err_o
  );

  modport slave (
    input  data_left_i,
    input  data_right_i,
    input  data_val_i,
    output ser_data_o,
    output ser_data_val_o,
    output busy_o,
    output err_o
  );

endinterface : priority_index_serializer_if
`default_nettype wire

// File: rtl/priority_index_serializer_onehot_to_index.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : onehot_to_index
//  Description : Combinational one-hot to binary index converter with
//                classification flags.
//  Ports       : data_i   [WIDTH] - candidate one-hot vector
//                index_o  [IDX_W] - bit position (valid when onehot_o=1)
//                zero_o           - no bit set
//                onehot_o         - exactly one bit set
//  Revision    : 1.0 - initial release
// ============================================================================
module onehot_to_index
  import priority_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int IDX_W = idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [IDX_W-1:0] index_o,
  output logic             zero_o,
  output logic             onehot_o
);

  logic w_multi;

  // OR-reduction of the positions of all set bits; exact for a one-hot
  // vector, and don't-care otherwise because onehot_o flags that case.
  always_comb begin
    index_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (data_i[i]) begin
        index_o = index_o | IDX_W'(i);
      end
    end
  end

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign w_multi  = |(data_i & (data_i - WIDTH'(1)));
  assign zero_o   = ~|data_i;
  assign onehot_o = ~zero_o & ~w_multi;

endmodule : onehot_to_index
`default_nettype wire

// File: rtl/priority_index_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : priority_index_serializer
//  Description : Accepts a left/right one-hot pair, converts both to bit
//                indices and shifts out a frame {NZ, left_idx, right_idx},
//                MSB first, one bit per clock. Malformed pairs raise err_o
//                instead of producing a frame. All outputs are registered.
//  Ports       : clk_i   - clock
//                srst_i  - synchronous active-high reset
//                bus     - priority_index_serializer_if.slave
//  Revision    : 1.0 - initial release
// ============================================================================
module priority_index_serializer
  import priority_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                          clk_i,
  input  logic                          srst_i,
  priority_index_serializer_if.slave    bus
);

  localparam int IDX_W = idx_w(WIDTH);
  localparam logic [IDX_W-1:0] c_cnt_init = IDX_W'(IDX_W - 1);

  // Index converters
  logic [IDX_W-1:0] w_left_idx;
  logic [IDX_W-1:0] w_right_idx;
  logic             w_left_zero;
  logic             w_right_zero;
  logic             w_left_onehot;
  logic             w_right_onehot;

  onehot_to_index #(.WIDTH(WIDTH)) u_left_conv (
    .data_i   (bus.data_left_i),
    .index_o  (w_left_idx),
    .zero_o   (w_left_zero),
    .onehot_o (w_left_onehot)
  );

  onehot_to_index #(.WIDTH(WIDTH)) u_right_conv (
    .data_i   (bus.data_right_i),
    .index_o  (w_right_idx),
    .zero_o   (w_right_zero),
    .onehot_o (w_right_onehot)
  );

  // Registers
  state_t           r_state;
  logic [IDX_W-1:0] r_left_sr;
  logic [IDX_W-1:0] r_right_sr;
  logic [IDX_W-1:0] r_cnt;
  logic             r_ser_data;
  logic             r_ser_val;
  logic             r_busy;
  logic             r_err;

  // Next-state values
  state_t           w_state_nxt;
  logic [IDX_W-1:0] w_left_sr_nxt;
  logic [IDX_W-1:0] w_right_sr_nxt;
  logic [IDX_W-1:0] w_cnt_nxt;
  logic             w_ser_data_nxt;
  logic             w_ser_val_nxt;
  logic             w_err_nxt;

  // Classification of the presented pair
  logic w_accept;
  logic w_zero_pair;
  logic w_norm_pair;

  // Acceptance looks at the registered busy flag only, so there is no
  // combinational path from the inputs to any output.
  assign w_accept    = bus.data_val_i & ~r_busy;
  assign w_zero_pair = w_left_zero & w_right_zero;
  assign w_norm_pair = w_left_onehot & w_right_onehot;

  // Outputs are computed one cycle ahead: each transition also produces the
  // bit that will be on the line while the machine sits in the new state.
  always_comb begin
    w_state_nxt    = r_state;
    w_left_sr_nxt  = r_left_sr;
    w_right_sr_nxt = r_right_sr;
    w_cnt_nxt      = r_cnt;
    w_ser_data_nxt = 1'b0;
    w_ser_val_nxt  = 1'b0;
    w_err_nxt      = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_zero_pair || w_norm_pair) begin
            w_state_nxt    = FLAG;
            w_left_sr_nxt  = w_norm_pair ? w_left_idx  : '0;
            w_right_sr_nxt = w_norm_pair ? w_right_idx : '0;
            w_ser_data_nxt = w_norm_pair;
            w_ser_val_nxt  = 1'b1;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end

      FLAG: begin
        w_state_nxt    = LEFT;
        w_ser_data_nxt = r_left_sr[IDX_W-1];
        w_ser_val_nxt  = 1'b1;
        w_left_sr_nxt  = r_left_sr << 1;
        w_cnt_nxt      = c_cnt_init;
      end

      LEFT: begin
        w_ser_val_nxt = 1'b1;
        if (r_cnt == '0) begin
          w_state_nxt    = RIGHT;
          w_ser_data_nxt = r_right_sr[IDX_W-1];
          w_right_sr_nxt = r_right_sr << 1;
          w_cnt_nxt      = c_cnt_init;
        end else begin
          w_ser_data_nxt = r_left_sr[IDX_W-1];
          w_left_sr_nxt  = r_left_sr << 1;
          w_cnt_nxt      = r_cnt - IDX_W'(1);
        end
      end

      RIGHT: begin
        if (r_cnt == '0) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_ser_val_nxt  = 1'b1;
          w_ser_data_nxt = r_right_sr[IDX_W-1];
          w_right_sr_nxt = r_right_sr << 1;
          w_cnt_nxt      = r_cnt - IDX_W'(1);
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_state    <= IDLE;
      r_left_sr  <= '0;
      r_right_sr <= '0;
      r_cnt      <= '0;
      r_ser_data <= 1'b0;
      r_ser_val  <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_left_sr  <= w_left_sr_nxt;
      r_right_sr <= w_right_sr_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ser_data <= w_ser_data_nxt;
      r_ser_val  <= w_ser_val_nxt;
      r_busy     <= (w_state_nxt != IDLE);
      r_err      <= w_err_nxt;
    end
  end

  assign bus.ser_data_o     = r_ser_data;
  assign bus.ser_data_val_o = r_ser_val;
  assign bus.busy_o         = r_busy;
  assign bus.err_o          = r_err;

endmodule : priority_index_serializer
`default_nettype wire

// File: doc/priority_index_serializer.md
# priority_index_serializer

Downstream stage of the priority encoder. Accepts one registered left/right one-hot pair per valid pulse, converts each one-hot to a binary bit index, and shifts a fixed-length frame out one bit per clock on a serial line. Malformed (non-one-hot) pairs are flagged instead of serialized. Drops in directly after the encoder's `data_left_o` / `data_right_o` / `data_val_o` outputs.

## Interface
- `WIDTH`, default 8: one-hot input width. Must be ≥ 2.
- `IDX_W`, derived, `$clog2(WIDTH)`: index width. Not overridable.
- `clk_i`  in  1: single clock. Every output is registered on it.
- `srst_i`  in  1: reset, synchronous, active-high.
- `data_left_i`  in  WIDTH: one-hot of the leftmost set bit, or all-zero.
- `data_right_i`  in  WIDTH: one-hot of the rightmost set bit, or all-zero.
- `data_val_i`  in  1: input pair is valid this cycle (single-cycle pulse).
- `ser_data_o`  out  1: serial frame bit.
- `ser_data_val_o`  out  1: `ser_data_o` is valid this cycle.
- `busy_o`  out  1: a frame is in progress; inputs are ignored while high.
- `err_o`  out  1: one-cycle pulse when an accepted pair is malformed.

## Operation
- **Frame length and order.** F = 1 + 2·IDX_W bits, sent in this order:
  - NZ flag: 1 if any input bit is set.
  - `left_idx`, MSB first.
  - `right_idx`, MSB first.
  - For WIDTH=8: F=7.
- **Acceptance.** A pair is accepted only when `data_val_i`=1 and `busy_o`=0 in the same cycle. A `data_val_i` seen while `busy_o`=1 is silently dropped; no queueing.
- **Classification of an accepted pair:**
  - Both inputs zero → zero frame: NZ=0, both indices 0.
  - Both inputs exactly one-hot → normal frame: NZ=1, indices = bit positions.
  - Anything else → malformed. This covers:
    - either input having ≥2 bits set;
    - exactly one of the two inputs being zero.
  - A malformed pair raises `err_o` and produces no frame.
- **Indices** are latched into a shift register at acceptance. Later input changes do not affect a frame in flight.
- **FSM states:**
  - IDLE: `busy_o`=0. Accepting a normal or zero pair → FLAG. Malformed pair → stay in IDLE.
  - FLAG: emit NZ → LEFT.
  - LEFT: emit IDX_W bits via a down-counter from IDX_W-1 → RIGHT when the counter reaches 0.
  - RIGHT: same as LEFT → IDLE after the last bit.
- `busy_o` = (state ≠ IDLE).
- **Reset.** State IDLE; all outputs 0; shift register and counter cleared. Reset mid-frame aborts the frame with no partial completion.

## Timing
- Pair accepted at rising edge N:
  - `busy_o` and `ser_data_val_o` are high on cycles N+1 … N+F.
  - NZ bit appears on N+1; last `right_idx` LSB on N+F.
  - `busy_o` returns low on N+F+1, so the earliest next acceptance is at N+F+1.
  - Minimum frame-to-frame spacing is F+1 cycles, with one idle gap.
- Malformed pair accepted at N: `err_o`=1 on cycle N+1 only. `busy_o` stays 0, so a new pair can be accepted at N+1.
- `ser_data_o`=0 whenever `ser_data_val_o`=0.
- `srst_i` high at edge N: all outputs 0 from cycle N+1, regardless of state. `data_val_i` is ignored while `srst_i`=1.
- Accept checks use registered `busy_o`. There is no combinational path from inputs to any output.

## Structure
- Shared package `priority_pkg`, used by both encoder and serializer benches:
  - `WIDTH` default;
  - IDX_W function;
  - `state_t` enum {IDLE, FLAG, LEFT, RIGHT};
  - frame-length constant.
- One sub-module: `onehot_to_index`, combinational, parameter `WIDTH`. Outputs `index_o` [IDX_W-1:0], `zero_o`, and `onehot_o` (exactly one bit set).
  - Instantiated twice, for left and right.
  - Its outputs feed the classification logic above.
- Top level holds the FSM, bit counter, shift register and output registers.

## Test plan
- **Normal pair:** left=8'h80, right=8'h01, val pulse at N → `ser_data_o` = 1,1,1,1,0,0,0 on N+1…N+7 with `ser_data_val_o`=1 and `busy_o`=1. Both are 0 at N+8.
- **Zero pair:** left=right=8'h00, val → frame 0,0,0,0,0,0,0 on N+1…N+7 with `ser_data_val_o`=1. `err_o` stays 0.
- **Single bit:** left=right=8'h10 → frame 1,1,0,0,1,0,0.
- **Malformed input:** left=8'h06, right=8'h02 → `err_o`=1 on N+1 only, `ser_data_val_o` stays 0. A normal pair at N+1 is accepted and its frame starts at N+2.
- **Drop while busy:** accept 8'h80/8'h01 at N, then pulse val with 8'h04/8'h04 at N+3 → only the first frame is emitted, unaltered. Nothing is emitted after N+7.
- **Reset mid-frame:** accept a pair at N, assert `srst_i` at N+3 → all outputs 0 from N+4. After reset drops, a new pair serializes correctly from its NZ bit.
